// File: rtl/fifo_skew_scheduler_pkg.sv
// fifo_skew_scheduler_pkg: shared state enum and default sizes for the skew scheduler
package DEFINE_PKG;
  typedef enum logic [1:0] {IDLE, RUN, DONE} SKEW_SCHED_STATE_t;
  localparam int SA_NUM_ROWS = 4;
  localparam int SA_K_W = 8;
endpackage

// File: rtl/fifo_skew_scheduler_window.sv
// skew_window: per-row activity window, row i active for cyc in [i, i+k_q)
module skew_window
  import DEFINE_PKG::*;
#(
  parameter int NUM_ROWS = SA_NUM_ROWS,
  parameter int K_W = SA_K_W,
  parameter int CNT_W = $clog2(2 ** K_W + NUM_ROWS)
) (
  input  logic [CNT_W-1:0]    cyc,
  input  logic [K_W-1:0]      k_q,
  output logic [NUM_ROWS-1:0] active
);
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    assign active[i] = (cyc >= CNT_W'(i)) && (cyc < CNT_W'(i) + CNT_W'(k_q));
  end
endmodule

// File: rtl/fifo_skew_scheduler.sv
// fifo_skew_scheduler: skewed row-FIFO read sequencer; FIFO_SKEW_SCHED_STALL_CNT_EN adds stall_cnt
module fifo_skew_scheduler
  import DEFINE_PKG::*;
#(
  parameter int NUM_ROWS = SA_NUM_ROWS,
  parameter int K_W = SA_K_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic                hold,
  input  logic [NUM_ROWS-1:0] fifo_empty,
  output logic [NUM_ROWS-1:0] rd_en,
  output logic                busy,
  output logic                done,
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
  output logic                stall,
  output logic [15:0]         stall_cnt
`else
  output logic                stall
`endif
);
  localparam int CNT_W = $clog2(2 ** K_W + NUM_ROWS);
  SKEW_SCHED_STATE_t state_q;
  logic [CNT_W-1:0] cyc_q;
  logic [K_W-1:0] k_q;
  logic [NUM_ROWS-1:0] active;
  logic run, last;
  skew_window #(.NUM_ROWS(NUM_ROWS), .K_W(K_W), .CNT_W(CNT_W)) u_win (
    .cyc(cyc_q),
    .k_q(k_q),
    .active(active)
  );
  assign run = state_q == RUN;
  assign stall = run & (hold | |(active & fifo_empty));
  assign rd_en = (run & ~stall) ? active : '0;
  assign last = cyc_q == CNT_W'(k_q) + CNT_W'(NUM_ROWS - 2);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q <= '0;
      k_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_q <= (k_len == '0) ? DONE : RUN;
        cyc_q <= '0;
        k_q <= k_len;
      end
    end else if (run) begin
      if (!stall) begin
        cyc_q <= cyc_q + CNT_W'(1);
        if (last) state_q <= DONE;
      end
    end else begin
      state_q <= IDLE;
    end
  end
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (state_q == IDLE && start) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// tb_fifo_skew_scheduler: scoreboard bench for the skewed row-FIFO read sequencer
module tb_fifo_skew_scheduler;
  localparam int N = 4;
  localparam int KW = 8;
  logic clk = 0, rst = 1, start = 0, hold = 0;
  logic [KW-1:0] k_len = '0;
  logic [N-1:0] fifo_empty = '0;
  logic [N-1:0] rd_en;
  logic busy, done, stall;
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, failures = 0, step = 0, busy_cyc = 0;
  logic expect_done = 0;
  logic [N-1:0] exp_q[$];
  fifo_skew_scheduler #(.NUM_ROWS(N), .K_W(KW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .k_len(k_len),
    .hold(hold),
    .fifo_empty(fifo_empty),
    .rd_en(rd_en),
    .busy(busy),
    .done(done),
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
    .stall(stall),
    .stall_cnt(stall_cnt)
`else
    .stall(stall)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    logic exp_st;
    logic [N-1:0] exp_rd;
    if (!rst) begin
      if (busy) busy_cyc++;
      checks++;
      if (exp_q.size() > 0) begin
        exp_st = hold | (|(exp_q[0] & fifo_empty));
        exp_rd = exp_st ? '0 : exp_q[0];
        if (stall !== exp_st || rd_en !== exp_rd || busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL run step=%0d rd_en=%b stall=%b busy=%b done=%b expected rd_en=%b stall=%b busy=1 done=0", step, rd_en, stall, busy, done, exp_rd, exp_st);
        end
        if (!exp_st) begin
          void'(exp_q.pop_front());
          step++;
          if (exp_q.size() == 0) expect_done = 1;
        end
      end else if (expect_done) begin
        if (done !== 1'b1 || busy !== 1'b1 || rd_en !== '0 || stall !== 1'b0) begin
          failures++;
          $display("FAIL done_cycle done=%b busy=%b rd_en=%b stall=%b expected 1 1 0000 0", done, busy, rd_en, stall);
        end
        expect_done = 0;
      end else if (done !== 1'b0 || busy !== 1'b0 || rd_en !== '0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL idle done=%b busy=%b rd_en=%b stall=%b expected all 0", done, busy, rd_en, stall);
      end
    end
  end
  task automatic push_tile(input int k);
    logic [N-1:0] p;
    step = 0;
    if (k == 0) expect_done = 1;
    else
      for (int t = 0; t <= k + N - 2; t++) begin
        for (int i = 0; i < N; i++) p[i] = (t >= i) && (t < i + k);
        exp_q.push_back(p);
      end
  endtask
  task automatic start_tile(input int k);
    start = 1;
    k_len = KW'(k);
    @(posedge clk);
    push_tile(k);
    #1 start = 0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 1000; n++) begin
      if (exp_q.size() == 0 && !expect_done) return;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle timeout remaining=%0d expected 0", exp_q.size());
    exp_q.delete();
    expect_done = 0;
  endtask
  task automatic wait_step(input int s);
    for (int n = 0; n < 1000; n++) begin
      if (step >= s) return;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL wait_step timeout step=%0d expected %0d", step, s);
  endtask
  task automatic check_busy(input string name, input int exp_n);
    checks++;
    if (busy_cyc !== exp_n) begin
      failures++;
      $display("FAIL %s busy_cycles=%0d expected %0d", name, busy_cyc, exp_n);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_en !== '0 || busy !== 0 || done !== 0 || stall !== 0) begin
      failures++;
      $display("FAIL reset rd_en=%b busy=%b done=%b stall=%b expected all 0", rd_en, busy, done, stall);
    end
    rst = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    busy_cyc = 0;
    start_tile(3);
    wait_idle();
    check_busy("basic", 7);
  endtask
  task automatic test_empty_stall();
    busy_cyc = 0;
    start_tile(3);
    wait_step(3);
    fifo_empty = 4'b0100;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    fifo_empty = '0;
    wait_idle();
    check_busy("empty_stall", 10);
  endtask
  task automatic test_hold_inactive();
    busy_cyc = 0;
    fifo_empty = 4'b1000;
    start_tile(5);
    wait_step(3);
    fifo_empty = '0;
    wait_step(5);
    hold = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    hold = 0;
    wait_idle();
    check_busy("hold", 11);
  endtask
  task automatic test_zero_len();
    busy_cyc = 0;
    start_tile(0);
    wait_idle();
    check_busy("zero_len", 1);
  endtask
  task automatic test_back_to_back();
    start_tile(4);
    wait_step(2);
    start = 1;
    k_len = 8'd9;
    @(posedge clk);
    #1 start = 0;
    for (int n = 0; n < 100 && !expect_done; n++) begin
      @(posedge clk);
      #1;
    end
    start = 1;
    k_len = 8'd9;
    @(posedge clk);
    #1 k_len = 8'd2;
    busy_cyc = 0;
    start_tile(2);
    wait_idle();
    check_busy("back_to_back", 6);
  endtask
  task automatic test_reset_mid();
    start_tile(6);
    wait_step(2);
    #2 rst = 1;
    #1;
    checks++;
    if (rd_en !== '0 || busy !== 0 || done !== 0 || stall !== 0) begin
      failures++;
      $display("FAIL reset_mid rd_en=%b busy=%b done=%b stall=%b expected all 0", rd_en, busy, done, stall);
    end
    exp_q.delete();
    expect_done = 0;
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    busy_cyc = 0;
    start_tile(2);
    wait_idle();
    check_busy("rearm", 6);
  endtask
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
  task automatic test_stall_cnt();
    start_tile(4);
    wait_step(1);
    hold = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    hold = 0;
    wait_idle();
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_cnt value=%0d expected 5", stall_cnt);
    end
    start_tile(1);
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_cnt_clear value=%0d expected 0", stall_cnt);
    end
    wait_idle();
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_empty_stall();
    test_hold_inactive();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
`ifdef FIFO_SKEW_SCHED_STALL_CNT_EN
    test_stall_cnt();
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
